// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the registered MIPS ALU.
// SEQ_ALU_DIVIDER_EN adds the DIV state for the iterative divider.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_LUI   = 4'b0101;
    localparam logic [3:0] OP_PASSB = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

`ifdef SEQ_ALU_DIVIDER_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
`else
    typedef enum logic [1:0] {IDLE, MUL} state_e;
`endif

endpackage

// File: rtl/seq_alu_if.sv
// Execute-stage request/result bundle between control unit and seq_alu.
// master: start, ALUOperation, A, B, shamt out; busy, done, result, flags in.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    logic [3:0]       ALUOperation;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Overflow;
    logic             DivByZero;

    modport master (
        output start, ALUOperation, A, B, shamt,
        input  busy, done, ALUResult, Zero, Overflow, DivByZero
    );

    modport slave (
        input  start, ALUOperation, A, B, shamt,
        output busy, done, ALUResult, Zero, Overflow, DivByZero
    );

endinterface

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider with HI/LO.
// Ports: clk, reset (async low); *_go_i load, *_run_i iterate; last_o marks
// the final step, fin_lo_o is the LO value written on it; hi_o/lo_o current.
// Divider ports and datapath exist only with SEQ_ALU_DIVIDER_EN.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mul_go_i,
    input  logic             mul_run_i,
`ifdef SEQ_ALU_DIVIDER_EN
    input  logic             div_go_i,
    input  logic             div_run_i,
    input  logic             dbz_go_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] fin_lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] step;
    logic [WIDTH:0]     acc;
    logic               run;
`ifdef SEQ_ALU_DIVIDER_EN
    logic [WIDTH:0]     cand;
    logic [WIDTH:0]     diff;

    assign run = mul_run_i | div_run_i;
`else
    assign run = mul_run_i;
`endif

    assign last_o   = run && (cnt_q == SHW'(WIDTH - 1));
    assign fin_lo_o = step[WIDTH-1:0];
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

    // w_q = {partial, multiplier} for MUL; {remainder, dividend/quotient} for DIV
    always_comb begin
        acc  = {1'b0, w_q[2*WIDTH-1:WIDTH]}
             + (w_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        step = {acc, w_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIVIDER_EN
        cand = w_q[2*WIDTH-1:WIDTH-1];
        diff = cand - {1'b0, m_q};
        // diff MSB set means the trial subtraction went negative: restore
        if (div_run_i) begin
            step = {(diff[WIDTH] ? cand[WIDTH-1:0] : diff[WIDTH-1:0]),
                    w_q[WIDTH-2:0], ~diff[WIDTH]};
        end
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        m_d   = m_q;
        w_d   = w_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (mul_go_i) begin
            m_d   = a_i;
            w_d   = {{WIDTH{1'b0}}, b_i};
            cnt_d = '0;
        end
`ifdef SEQ_ALU_DIVIDER_EN
        else if (div_go_i) begin
            m_d   = b_i;
            w_d   = {{WIDTH{1'b0}}, a_i};
            cnt_d = '0;
        end
        else if (dbz_go_i) begin
            hi_d = a_i;
            lo_d = '1;
        end
`endif
        else if (run) begin
            w_d   = step;
            cnt_d = cnt_q + SHW'(1);
            if (last_o) begin
                hi_d = step[2*WIDTH-1:WIDTH];
                lo_d = step[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            m_q   <= '0;
            w_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            m_q   <= m_d;
            w_q   <= w_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle ops, flags, and the FSM
// driving seq_muldiv. Ports: clk, reset (async low), bus (seq_alu_if.slave).
// Define SEQ_ALU_DIVIDER_EN to build the iterative DIVU path.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    seq_alu_if.slave   bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum, dif, lui;
    logic             slt, sltu;

    logic             mul_go;
    logic             last;
    logic [WIDTH-1:0] fin_lo, hi, lo;
`ifdef SEQ_ALU_DIVIDER_EN
    logic             div_go, dbz_go;
`endif

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .mul_go_i  (mul_go),
        .mul_run_i (state_q == MUL),
`ifdef SEQ_ALU_DIVIDER_EN
        .div_go_i  (div_go),
        .div_run_i (state_q == DIV),
        .dbz_go_i  (dbz_go),
`endif
        .a_i       (bus.A),
        .b_i       (bus.B),
        .last_o    (last),
        .fin_lo_o  (fin_lo),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always_comb begin
        sum  = bus.A + bus.B;
        dif  = bus.A - bus.B;
        slt  = $signed(bus.A) < $signed(bus.B);
        sltu = bus.A < bus.B;
        // {B[15:0], 16'b0}, with bits above 31 kept zero on wide datapaths
        lui  = bus.B << 16;
        for (int i = 32; i < WIDTH; i++) lui[i] = 1'b0;
        alu_ovf = 1'b0;
        alu_res = '0;
        unique case (bus.ALUOperation)
            OP_AND:   alu_res = bus.A & bus.B;
            OP_OR:    alu_res = bus.A | bus.B;
            OP_NOR:   alu_res = ~(bus.A | bus.B);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1])
                       && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1])
                       && (dif[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_LUI:   alu_res = lui;
            OP_PASSB: alu_res = bus.B;
            OP_SLL:   alu_res = bus.B << bus.shamt;
            OP_SRL:   alu_res = bus.B >> bus.shamt;
            OP_SRA:   alu_res = $unsigned($signed(bus.B) >>> bus.shamt);
            OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, sltu};
            OP_MFHI:  alu_res = hi;
            OP_MFLO:  alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        mul_go  = 1'b0;
`ifdef SEQ_ALU_DIVIDER_EN
        div_go  = 1'b0;
        dbz_go  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dbz_d = 1'b0;
                    if (bus.ALUOperation == OP_MULTU) begin
                        mul_go  = 1'b1;
                        state_d = MUL;
                    end
`ifdef SEQ_ALU_DIVIDER_EN
                    else if (bus.ALUOperation == OP_DIVU
                             && bus.B != '0) begin
                        div_go  = 1'b1;
                        state_d = DIV;
                    end
                    else if (bus.ALUOperation == OP_DIVU) begin
                        dbz_go = 1'b1;
                        res_d  = '1;
                        zero_d = 1'b0;
                        ovf_d  = 1'b0;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end
`endif
                    else begin
                        res_d  = alu_res;
                        zero_d = (alu_res == '0);
                        ovf_d  = alu_ovf;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                if (last) begin
                    res_d   = fin_lo;
                    zero_d  = (fin_lo == '0);
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.ALUResult = res_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = ovf_q;
    assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: scoreboard of expected results checked on done.
module tb_seq_alu;
    import alu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        dbz;
        int          lat;
        int          t0;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   fails;
    int   ndone;
    exp_t sbq[$];

    seq_alu_if #(.WIDTH(32)) ifc ();

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] er,
                         input logic eov, input logic edz, input int lat);
        exp_t e;
        ifc.start        = 1'b1;
        ifc.ALUOperation = op;
        ifc.A            = a;
        ifc.B            = b;
        ifc.shamt        = sh;
        e.tag  = tag;
        e.res  = er;
        e.zero = (er == 32'd0);
        e.ovf  = eov;
        e.dbz  = edz;
        e.lat  = lat;
        e.t0   = cyc;
        sbq.push_back(e);
        tick();
        ifc.start = 1'b0;
    endtask

    // scoreboard consumer: every done pulse must match the oldest request
    always @(negedge clk) begin
        if (rst_n && ifc.done) begin
            ndone++;
            chk("done_has_request", 32'(sbq.size() != 0), 32'd1);
            chk("done_not_busy", 32'(ifc.busy), 32'd0);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.tag, "_res"}, ifc.ALUResult, e.res);
                chk({e.tag, "_zero"}, 32'(ifc.Zero), 32'(e.zero));
                chk({e.tag, "_ovf"}, 32'(ifc.Overflow), 32'(e.ovf));
                chk({e.tag, "_dbz"}, 32'(ifc.DivByZero), 32'(e.dbz));
                chk({e.tag, "_lat"}, cyc - e.t0, e.lat);
            end
        end
    end

    initial begin
        logic [63:0] prod;
        int          nd0;
        cyc = 0; checks = 0; fails = 0; ndone = 0;
        rst_n = 1'b0;
        ifc.start = 1'b0; ifc.ALUOperation = 4'd0;
        ifc.A = '0; ifc.B = '0; ifc.shamt = '0;
        tick(); tick();
        chk("rst_res", ifc.ALUResult, 32'd0);
        chk("rst_zero", 32'(ifc.Zero), 32'd1);
        chk("rst_ovf", 32'(ifc.Overflow), 32'd0);
        chk("rst_dbz", 32'(ifc.DivByZero), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        rst_n = 1'b1;
        tick();

        // single-cycle ops, issued back to back
        issue("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1, 0, 1);
        issue("sub_zero", OP_SUB, 32'd5, 32'd5, 5'd0, 32'd0, 0, 0, 1);
        issue("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1, 0, 1);
        issue("add_neg", OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 0, 0, 1);
        issue("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 0, 0, 1);
        issue("or", OP_OR, 32'hF000_0000, 32'h0000_000F, 5'd0, 32'hF000_000F, 0, 0, 1);
        issue("nor", OP_NOR, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 0, 0, 1);
        issue("lui", OP_LUI, 32'd0, 32'h1234_ABCD, 5'd0, 32'hABCD_0000, 0, 0, 1);
        issue("passb", OP_PASSB, 32'd7, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 0, 0, 1);
        issue("sll", OP_SLL, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 0, 0, 1);
        issue("sra", OP_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 0, 0, 1);
        issue("srl", OP_SRL, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 0, 0, 1);
        issue("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 0, 0, 1);
        issue("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 0, 0, 1);
        tick();

        // MULTU with busy window, then back-to-back MFHI in the done cycle
        issue("multu1", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'hFFFF_FFFE, 0, 0, 33);
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("mul_busy_c%0d", i), 32'(ifc.busy), 32'd1);
            tick();
        end
        chk("mul_busy_c33", 32'(ifc.busy), 32'd0);
        issue("mfhi1", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd1, 0, 0, 1);
        issue("mflo1", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFE, 0, 0, 1);
        tick();

`ifdef SEQ_ALU_DIVIDER_EN
        issue("divu", OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 0, 0, 33);
        repeat (32) tick();
        issue("mfhi_div", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd2, 0, 0, 1);
        issue("mflo_div", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd14, 0, 0, 1);
        issue("divu0", OP_DIVU, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 0, 1, 1);
        chk("div0_busy", 32'(ifc.busy), 32'd0);
        issue("mfhi_dz", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd9, 0, 0, 1);
        issue("mflo_dz", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 0, 0, 1);
`else
        issue("divu_off", OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd0, 0, 0, 1);
        chk("divu_off_busy", 32'(ifc.busy), 32'd0);
        issue("divu0_off", OP_DIVU, 32'd9, 32'd0, 5'd0, 32'd0, 0, 0, 1);
        issue("mfhi_off", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd1, 0, 0, 1);
        issue("mflo_off", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFE, 0, 0, 1);
`endif
        tick();

        // start while busy is ignored
        prod = 64'h1234_5678 * 64'h9ABC_DEF0;
        issue("multu2", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, prod[31:0], 0, 0, 33);
        repeat (8) tick();
        ifc.start = 1'b1; ifc.ALUOperation = OP_ADD;
        ifc.A = 32'd1; ifc.B = 32'd1;
        tick();
        ifc.start = 1'b0;
        repeat (23) tick();
        issue("mfhi2", OP_MFHI, 32'd0, 32'd0, 5'd0, prod[63:32], 0, 0, 1);
        issue("mflo2", OP_MFLO, 32'd0, 32'd0, 5'd0, prod[31:0], 0, 0, 1);

        // async reset in the middle of a MULTU
        issue("add_ovf2", OP_ADD, 32'h4000_0000, 32'h4000_0000, 5'd0, 32'h8000_0000, 1, 0, 1);
        issue("multu3", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd1, 0, 0, 33);
        repeat (14) tick();
        rst_n = 1'b0;
        #1;
        sbq.delete();
        nd0 = ndone;
        chk("mrst_busy", 32'(ifc.busy), 32'd0);
        chk("mrst_res", ifc.ALUResult, 32'd0);
        chk("mrst_zero", 32'(ifc.Zero), 32'd1);
        chk("mrst_ovf", 32'(ifc.Overflow), 32'd0);
        chk("mrst_done", 32'(ifc.done), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("mrst_no_done", ndone, nd0);
        issue("mfhi_rst", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0, 1);
        issue("mflo_rst", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0, 1);
        tick(); tick();
        chk("sb_drained", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
